// File: rtl/ss_chan_pkg.sv
// rtl/ss_chan_pkg.sv - shared widths, entry type and byte-swap helper for the channel buffer
package ss_chan_pkg;

  // One FIFO entry: stream-side last tag plus the 64-bit memory word.
  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } entry_t;

  // Pointer width: pointers wrap modulo DEPTH.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Entry count needs one extra bit so full (DEPTH) differs from empty (0).
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Occupancy in 32-bit words: up to 2*DEPTH.
  function automatic int ocnt_w(input int depth);
    return $clog2(depth) + 2;
  endfunction

  // {b0,b1,b2,b3} byte reversal of a 32-bit word.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/ss_chan_buf_if.sv
// rtl/ss_chan_buf_if.sv - memory-side and stream-side signal bundle of the channel buffer
// master: memory engine / stream consumer side (drives pushes, xfer, m_reset, dc_len)
// slave : ss_chan_buf (drives data, status and error flags)
interface ss_chan_buf_if
  import ss_chan_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LW    = 24
);
  localparam int OW = ocnt_w(DEPTH);

  logic          m_reset;
  logic [LW-1:0] dc_len;
  logic [63:0]   m_dst;
  logic          m_dst_putn;
  logic          m_dst_last;
  logic          m_full;
  logic          m_almost_full;
  logic          ss_xfer;
  logic [31:0]   ss_dat_i;
  logic          ss_stop;
  logic          ss_last;
  logic          ss_end;
  logic          ss_almost_empty;
  logic [OW-1:0] ocnt;
  logic          err_ovf;
  logic          err_udf;

  modport master (
    output m_reset, dc_len, m_dst, m_dst_putn, m_dst_last, ss_xfer,
    input  m_full, m_almost_full, ss_dat_i, ss_stop, ss_last, ss_end,
           ss_almost_empty, ocnt, err_ovf, err_udf
  );

  modport slave (
    input  m_reset, dc_len, m_dst, m_dst_putn, m_dst_last, ss_xfer,
    output m_full, m_almost_full, ss_dat_i, ss_stop, ss_last, ss_end,
           ss_almost_empty, ocnt, err_ovf, err_udf
  );

endinterface

// File: rtl/ss_chan_ram.sv
// rtl/ss_chan_ram.sv - DEPTH x 65 simple dual-port storage, synchronous write, asynchronous read
// clk   : write clock
// we    : write enable
// waddr : write address, wdata : entry to store
// raddr : read address,  rdata : entry at raddr (combinational)
module ss_chan_ram
  import ss_chan_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PW   = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [PW-1:0] raddr,
  output entry_t        rdata
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ss_chan_buf.sv
// rtl/ss_chan_buf.sv - 64-bit memory-to-32-bit stream channel buffer with length counter, watermarks and error flags
// wb_clk_i : clock (rising edge)
// wb_rst_i : asynchronous active-low reset
// bus      : ss_chan_buf_if.slave - push side (m_*), stream side (ss_*), ocnt, err_ovf, err_udf,
//            m_reset/dc_len flush and length load
// Optional feature: SS_CHAN_BUF_BSWAP_EN byte-reverses each 32-bit word on ss_dat_i.
module ss_chan_buf
  import ss_chan_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2,
  parameter int LW     = 24
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  ss_chan_buf_if.slave bus
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam int OW = ocnt_w(DEPTH);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          sel;
  logic [LW-1:0] rem;
  logic          full_q, afull_q, aempty_q, end_q, ovf_q, udf_q;
  logic [OW-1:0] ocnt_q;

  logic          empty, stop, push, acc, last_acc, pop;
  logic [CW-1:0] cnt_d;
  logic          sel_d;
  logic [OW-1:0] ocnt_d;
  logic [31:0]   word;
  entry_t        head, wentry;
  logic          unused_last;

  assign empty    = (cnt == '0);
  assign stop     = empty | (rem == '0);
  // Full is judged on the registered flag, so a same-cycle pop never frees room for a push.
  assign push     = ~bus.m_dst_putn & ~full_q;
  assign acc      = bus.ss_xfer & ~stop;
  assign last_acc = acc & (rem == LW'(1));
  // The final word retires its entry even when only the low half was consumed.
  assign pop      = acc & (sel | last_acc);

  // Next count/select including the flush, so registered flags track the real next state.
  always_comb begin
    cnt_d = cnt;
    sel_d = sel;
    if (bus.m_reset) begin
      cnt_d = '0;
      sel_d = 1'b0;
    end else begin
      if (push && !pop)      cnt_d = cnt + CW'(1);
      else if (pop && !push) cnt_d = cnt - CW'(1);
      if (pop)               sel_d = 1'b0;
      else if (acc)          sel_d = 1'b1;
    end
    ocnt_d = {cnt_d, 1'b0} - OW'(sel_d);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      sel      <= 1'b0;
      rem      <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      end_q    <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      ocnt_q   <= '0;
    end else begin
      cnt      <= cnt_d;
      sel      <= sel_d;
      ocnt_q   <= ocnt_d;
      full_q   <= (cnt_d == CW'(DEPTH));
      afull_q  <= (cnt_d >= CW'(AF_LVL));
      aempty_q <= (cnt_d <= CW'(AE_LVL));
      if (bus.m_reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        rem    <= bus.dc_len;
        end_q  <= 1'b0;
        ovf_q  <= 1'b0;
        udf_q  <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (acc)  rem    <= rem - LW'(1);
        end_q <= last_acc;
        ovf_q <= ovf_q | (~bus.m_dst_putn & full_q);
        udf_q <= udf_q | (bus.ss_xfer & stop);
      end
    end
  end

  assign wentry = '{last: bus.m_dst_last, data: bus.m_dst};

  ss_chan_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (wb_clk_i),
    .we    (push & ~bus.m_reset),
    .waddr (wr_ptr),
    .wdata (wentry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Stream-side termination is length-driven; the stored tag is kept for the datapath record only.
  assign unused_last = head.last;

`ifdef SS_CHAN_BUF_BSWAP_EN
  assign word = bswap32(sel ? head.data[63:32] : head.data[31:0]);
`else
  assign word = sel ? head.data[63:32] : head.data[31:0];
`endif

  // Storage is not reset, so hold the data bus at zero while nothing is buffered.
  assign bus.ss_dat_i        = empty ? 32'h0 : word;
  assign bus.ss_stop         = stop;
  assign bus.ss_last         = (rem == LW'(1)) & ~empty;
  assign bus.ss_end          = end_q;
  assign bus.m_full          = full_q;
  assign bus.m_almost_full   = afull_q;
  assign bus.ss_almost_empty = aempty_q;
  assign bus.ocnt            = ocnt_q;
  assign bus.err_ovf         = ovf_q;
  assign bus.err_udf         = udf_q;

endmodule

// File: tb/tb_ss_chan_buf.sv
// tb/tb_ss_chan_buf.sv - self-checking bench for ss_chan_buf (DEPTH=4)
module tb_ss_chan_buf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ss_chan_buf_if #(.DEPTH(4), .LW(24)) bus ();

  ss_chan_buf #(.DEPTH(4), .AF_LVL(2), .AE_LVL(2), .LW(24)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] sbq[$];

  function automatic logic [31:0] xw(input logic [31:0] w);
`ifdef SS_CHAN_BUF_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, ".m_full"}, bus.m_full, 0);
    chk({tag, ".m_af"}, bus.m_almost_full, 0);
    chk({tag, ".stop"}, bus.ss_stop, 1);
    chk({tag, ".last"}, bus.ss_last, 0);
    chk({tag, ".end"}, bus.ss_end, 0);
    chk({tag, ".ss_ae"}, bus.ss_almost_empty, 1);
    chk({tag, ".ocnt"}, bus.ocnt, 0);
    chk({tag, ".ovf"}, bus.err_ovf, 0);
    chk({tag, ".udf"}, bus.err_udf, 0);
    chk({tag, ".dat"}, bus.ss_dat_i, 0);
  endtask

  task automatic flush(input logic [23:0] len);
    bus.m_reset = 1'b1;
    bus.dc_len  = len;
    tick();
    bus.m_reset = 1'b0;
    sbq.delete();
  endtask

  task automatic push(input logic [63:0] d, input logic accept);
    bus.m_dst      = d;
    bus.m_dst_putn = 1'b0;
    tick();
    bus.m_dst_putn = 1'b1;
    if (accept) begin
      sbq.push_back(d[31:0]);
      sbq.push_back(d[63:32]);
    end
  endtask

  task automatic consume(input string tag, input logic exp_last);
    logic [31:0] e;
    chk({tag, ".stop"}, bus.ss_stop, 0);
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s.sb observed=empty expected=entry", tag);
      e = '0;
    end else begin
      e = sbq.pop_front();
    end
    chk({tag, ".dat"}, bus.ss_dat_i, xw(e));
    chk({tag, ".last"}, bus.ss_last, exp_last);
    bus.ss_xfer = 1'b1;
    tick();
    bus.ss_xfer = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] e;
    bus.m_reset    = 1'b0;
    bus.dc_len     = '0;
    bus.m_dst      = '0;
    bus.m_dst_putn = 1'b1;
    bus.m_dst_last = 1'b0;
    bus.ss_xfer    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // Basic transfer, dc_len=4
    flush(24'd4);
    push(64'h1111_2222_3333_4444, 1'b1);
    chk("basic.ocnt1", bus.ocnt, 2);
    chk("basic.af1", bus.m_almost_full, 0);
    chk("basic.ae1", bus.ss_almost_empty, 1);
    push(64'h5555_6666_7777_8888, 1'b1);
    chk("basic.ocnt2", bus.ocnt, 4);
    chk("basic.af2", bus.m_almost_full, 1);
    consume("b0", 1'b0);
    chk("basic.ocnt3", bus.ocnt, 3);
    consume("b1", 1'b0);
    chk("basic.ocnt4", bus.ocnt, 2);
    consume("b2", 1'b0);
    chk("basic.ocnt5", bus.ocnt, 1);
    consume("b3", 1'b1);
    chk("basic.end", bus.ss_end, 1);
    chk("basic.ocnt6", bus.ocnt, 0);
    chk("basic.stop", bus.ss_stop, 1);
    tick();
    chk("basic.end_off", bus.ss_end, 0);

    // Overflow
    flush(24'd100);
    for (int i = 0; i < 4; i++)
      push({32'hA000_0001 + 32'(2 * i), 32'hA000_0000 + 32'(2 * i)}, 1'b1);
    chk("ovf.full", bus.m_full, 1);
    chk("ovf.af", bus.m_almost_full, 1);
    chk("ovf.ae", bus.ss_almost_empty, 0);
    chk("ovf.ocnt", bus.ocnt, 8);
    chk("ovf.err0", bus.err_ovf, 0);
    push(64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    chk("ovf.err", bus.err_ovf, 1);
    chk("ovf.ocnt5", bus.ocnt, 8);
    chk("ovf.full5", bus.m_full, 1);
    for (int i = 0; i < 8; i++) consume("ovf_drain", 1'b0);
    chk("ovf.drain_ocnt", bus.ocnt, 0);
    chk("ovf.drain_full", bus.m_full, 0);
    chk("ovf.drain_stop", bus.ss_stop, 1);

    // Underrun
    bus.ss_xfer = 1'b1;
    tick();
    bus.ss_xfer = 1'b0;
    chk("udf.err", bus.err_udf, 1);
    chk("udf.ocnt", bus.ocnt, 0);
    chk("udf.ovf_sticky", bus.err_ovf, 1);
    push(64'hCAFE_0002_CAFE_0001, 1'b1);
    consume("udf_after", 1'b0);
    chk("udf.ocnt_after", bus.ocnt, 1);

    // m_reset with simultaneous push and xfer; odd length 3
    bus.m_reset    = 1'b1;
    bus.dc_len     = 24'd3;
    bus.m_dst      = 64'h9999_9999_9999_9999;
    bus.m_dst_putn = 1'b0;
    bus.ss_xfer    = 1'b1;
    tick();
    bus.m_reset    = 1'b0;
    bus.m_dst_putn = 1'b1;
    bus.ss_xfer    = 1'b0;
    sbq.delete();
    chk("prio.ocnt", bus.ocnt, 0);
    chk("prio.stop", bus.ss_stop, 1);
    chk("prio.ovf", bus.err_ovf, 0);
    chk("prio.udf", bus.err_udf, 0);
    push(64'h0B0B_0002_0B0B_0001, 1'b1);
    push(64'h0C0C_0002_0C0C_0001, 1'b1);
    consume("odd0", 1'b0);
    consume("odd1", 1'b0);
    consume("odd2", 1'b1);
    void'(sbq.pop_front());
    chk("odd.end", bus.ss_end, 1);
    chk("odd.stop", bus.ss_stop, 1);
    chk("odd.ocnt", bus.ocnt, 0);
    push(64'h0D0D_0002_0D0D_0001, 1'b1);
    chk("odd.held_ocnt", bus.ocnt, 2);
    chk("odd.held_stop", bus.ss_stop, 1);
    chk("odd.held_last", bus.ss_last, 0);

    // Simultaneous push and pop at 3 entries
    flush(24'd100);
    for (int i = 0; i < 3; i++)
      push({32'hE000_0001 + 32'(2 * i), 32'hE000_0000 + 32'(2 * i)}, 1'b1);
    consume("cc0", 1'b0);
    chk("cc.ocnt5", bus.ocnt, 5);
    e = sbq.pop_front();
    chk("cc.dat", bus.ss_dat_i, xw(e));
    bus.m_dst      = 64'hF000_0002_F000_0001;
    bus.m_dst_putn = 1'b0;
    bus.ss_xfer    = 1'b1;
    tick();
    bus.m_dst_putn = 1'b1;
    bus.ss_xfer    = 1'b0;
    sbq.push_back(32'hF000_0001);
    sbq.push_back(32'hF000_0002);
    chk("cc.ocnt6", bus.ocnt, 6);
    chk("cc.full", bus.m_full, 0);
    chk("cc.af", bus.m_almost_full, 1);
    for (int i = 0; i < 6; i++) consume("cc_drain", 1'b0);
    chk("cc.drain_ocnt", bus.ocnt, 0);

    // Byte swap (or pass-through in the default build)
    flush(24'd100);
    push(64'h0000_0000_0102_0304, 1'b1);
`ifdef SS_CHAN_BUF_BSWAP_EN
    chk("bswap.first", bus.ss_dat_i, 32'h0403_0201);
`else
    chk("bswap.first", bus.ss_dat_i, 32'h0102_0304);
`endif
    consume("bs0", 1'b0);
    consume("bs1", 1'b0);

    // Asynchronous reset mid-stream
    push(64'h1234_5678_9ABC_DEF0, 1'b1);
    push(64'h1357_9BDF_2468_ACE0, 1'b1);
    consume("ar0", 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    reset_vals("arst");
    tick();
    rst_n = 1'b1;
    tick();
    sbq.delete();
    reset_vals("arst_rel");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
